multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Multi-cycle sequencer for the RV32I-subset core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
// - Drives datapath enables/selects; owns the single shared memory port (instruction vs data) via req/ready handshake.
// - Sits between the instruction register/PC datapath and the unified memory; replaces per-cycle combinational control.
// PARAMETERS
// - MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ready; 0 = no timeout
// - CNT_W        32  width of performance counters
// PORTS
// - clk          in   1      single clock, rising edge
// - rst_n        in   1      asynchronous, active-low reset
// - run          in   1      1 = allowed to start a new FETCH
// - opcode       in   7      IR[6:0]
// - func3        in   3      IR[14:12]
// - func7        in   7      IR[31:25]
// - zero         in   1      ALU zero flag (valid in EXEC)
// - mem_ready    in   1      memory completes current request this cycle
// - mem_req      out  1      memory request, held until mem_ready
// - mem_we       out  1      1 = write (SW only)
// - mem_sel      out  1      address select: 0 = PC, 1 = ALU result
// - ir_write     out  1      load IR and latch old_pc
// - pc_write     out  1      load PC from pcsrc mux
// - pcsrc        out  2      00 PC+4, 01 old_pc+imm (JAL/BEQ), 10 rs1+imm (JALR)
// - regwrite     out  1      register-file write strobe
// - memtoreg     out  2      00 ALU, 01 mem data, 10 old_pc+4
// - alusrc       out  1      0 = rs2, 1 = immediate
// - aluop        out  3      011 ADD, 111 SUB, 001 AND, 000 OR, 010 XOR, 110 SLT
// - halted       out  1      sticky: illegal instruction or bus error
// - bus_err      out  1      sticky: halt caused by memory timeout
// - cycle_cnt    out  CNT_W  cycles in non-HALT states
// - instret_cnt  out  CNT_W  instructions retired
// BEHAVIOUR
// - Reset (async, any state, mid-transaction included): state=FETCH; every output 0; counters 0; mem_req drops immediately.
// - Decode classes: R 0110011, I 0010011, LW 0000011, SW 0100011, BEQ 1100011, JAL 1101111, JALR 1100111.
// - Illegal: any other opcode; R/I with func3 001 or 101 (shifts); BEQ with func3!=000; R with func7 not 0000000/0100000.
// - aluop: add/addi/LW/SW/JALR=011; sub (func7[5]=1, R)=111; BEQ=111; func3 111=001, 110=000, 100=010, 010/011=110.
// - FETCH: if run: mem_req=1, mem_sel=0, mem_we=0. On mem_ready: ir_write=1, pc_write=1, pcsrc=00 (same cycle) -> DECODE.
//   run=0: idle in FETCH, no request. run is sampled only at FETCH entry/idle; deassertion mid-instruction ignored.
// - DECODE (1 cycle): illegal -> HALT (halted=1); else -> EXEC.
// - EXEC (1 cycle): alusrc/aluop driven per class (alusrc=1 for I/LW/SW/JALR).
//   BEQ: if zero, pc_write=1, pcsrc=01; retire -> FETCH. LW/SW -> MEM. R/I/JAL/JALR -> WB.
// - MEM: mem_req=1, mem_sel=1, mem_we=SW; alusrc/aluop held (011). On mem_ready: SW retires -> FETCH; LW -> WB.
// - WB (1 cycle): regwrite=1; memtoreg 00 R/I, 01 LW, 10 JAL/JALR; JAL pc_write=1 pcsrc=01; JALR pc_write=1 pcsrc=10;
//   retire -> FETCH.
// - mem_ready while mem_req=0 is ignored. mem_ready in the first request cycle -> zero-wait (FETCH = 1 cycle).
// - Timeout: wait counter clears on each new request; increments each cycle mem_req=1 && !mem_ready;
//   reaching MEM_TIMEOUT -> HALT, halted=1, bus_err=1, mem_req=0 next cycle. MEM_TIMEOUT=0: never times out.
// - HALT: all strobes 0; exit only by reset.
// - Strobes (ir_write, pc_write, regwrite) are single-cycle; at most one retire per instruction.
// - Latency (zero-wait memory): R/I/JAL/JALR 4, BEQ 3, SW 4, LW 5 cycles.
// CONFIGURATION
// - PERF_CNT_EN defined: cycle_cnt += 1 every cycle state!=HALT && !(FETCH && !run);
//   instret_cnt += 1 on each retire; both wrap modulo 2^CNT_W.
// - PERF_CNT_EN undefined: counter logic absent, cycle_cnt and instret_cnt tied to 0.
// TESTING
// - add x3,x1,x2, mem_ready=1 always -> FETCH,DECODE,EXEC,WB; regwrite=1 cycle 4, memtoreg=00, aluop=011; instret=1.
// - LW with mem_ready delayed 3 cycles in MEM -> mem_req=1,mem_sel=1 held 4 cycles; then WB memtoreg=01; total 8 cycles.
// - BEQ func3=000 with zero=1 -> EXEC pc_write=1, pcsrc=01, aluop=111; zero=0 -> pc_write=0; both back to FETCH.
// - opcode 1111111 -> DECODE->HALT, halted=1, bus_err=0, no further mem_req even with run=1.
// - mem_ready stuck 0 in FETCH, MEM_TIMEOUT=16 -> halted=1, bus_err=1 after 16 wait cycles; mem_req low next cycle.
// - rst_n low mid-MEM of SW -> mem_req/mem_we drop asynchronously; after release state=FETCH, counters 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pcsrc,
    output logic             regwrite,
    output logic [1:0]       memtoreg,
    output logic             alusrc,
    output logic [2:0]       aluop,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_JALR, C_ILL
    } cls_t;

    state_t      state, state_nx;
    cls_t        cls;
    logic [2:0]  dec_aluop;
    logic        dec_alusrc;
    logic        fetch_busy;
    logic [31:0] wait_cnt;
    logic        bus_err_q;
    logic        req_int;
    logic        timeout;

    always_comb begin
        cls = C_ILL;
        case (opcode)
            7'b0110011: cls = C_R;
            7'b0010011: cls = C_I;
            7'b0000011: cls = C_LW;
            7'b0100011: cls = C_SW;
            7'b1100011: cls = C_BEQ;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            default:    cls = C_ILL;
        endcase
        if ((cls == C_R || cls == C_I) && (func3 == 3'b001 || func3 == 3'b101))
            cls = C_ILL;
        if (cls == C_BEQ && func3 != 3'b000)
            cls = C_ILL;
        if (cls == C_R && func7 != 7'b0000000 && func7 != 7'b0100000)
            cls = C_ILL;
    end

    always_comb begin
        dec_aluop = 3'b011;
        case (cls)
            C_BEQ: dec_aluop = 3'b111;
            C_R, C_I: begin
                case (func3)
                    3'b000:         dec_aluop = (cls == C_R && func7[5]) ? 3'b111 : 3'b011;
                    3'b111:         dec_aluop = 3'b001;
                    3'b110:         dec_aluop = 3'b000;
                    3'b100:         dec_aluop = 3'b010;
                    3'b010, 3'b011: dec_aluop = 3'b110;
                    default:        dec_aluop = 3'b011;
                endcase
            end
            default: dec_aluop = 3'b011;
        endcase
        dec_alusrc = (cls == C_I) || (cls == C_LW) || (cls == C_SW) || (cls == C_JALR);
    end

    // Once a fetch request is issued it is held to completion even if run drops.
    assign req_int = ((state == S_FETCH) && (run || fetch_busy)) || (state == S_MEM);
    assign timeout = (MEM_TIMEOUT != 0) && req_int && !mem_ready &&
                     (wait_cnt == MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            fetch_busy <= 1'b0;
            wait_cnt   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            fetch_busy <= (state == S_FETCH) && req_int && !mem_ready && !timeout;
            wait_cnt   <= (req_int && !mem_ready) ? wait_cnt + 32'd1 : '0;
            bus_err_q  <= bus_err_q | timeout;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (timeout)                  state_nx = S_HALT;
                else if (req_int && mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = (cls == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_BEQ:      state_nx = S_FETCH;
                    C_LW, C_SW: state_nx = S_MEM;
                    default:    state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (timeout)        state_nx = S_HALT;
                else if (mem_ready) state_nx = (cls == C_SW) ? S_FETCH : S_WB;
            end
            S_WB:    state_nx = S_FETCH;
            default: state_nx = S_HALT;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_sel  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pcsrc    = 2'b00;
        regwrite = 1'b0;
        memtoreg = 2'b00;
        alusrc   = 1'b0;
        aluop    = 3'b000;
        halted   = 1'b0;
        bus_err  = bus_err_q;
        case (state)
            S_FETCH: begin
                mem_req = req_int;
                if (req_int && mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                alusrc = dec_alusrc;
                aluop  = dec_aluop;
                if (cls == C_BEQ && zero) begin
                    pc_write = 1'b1;
                    pcsrc    = 2'b01;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (cls == C_SW);
                alusrc  = dec_alusrc;
                aluop   = dec_aluop;
            end
            S_WB: begin
                regwrite = 1'b1;
                case (cls)
                    C_LW:    memtoreg = 2'b01;
                    C_JAL: begin
                        memtoreg = 2'b10;
                        pc_write = 1'b1;
                        pcsrc    = 2'b01;
                    end
                    C_JALR: begin
                        memtoreg = 2'b10;
                        pc_write = 1'b1;
                        pcsrc    = 2'b10;
                    end
                    default: memtoreg = 2'b00;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        // Reset forces the memory port idle immediately, not at the next edge.
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_sel  = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            pcsrc    = 2'b00;
            regwrite = 1'b0;
            memtoreg = 2'b00;
            alusrc   = 1'b0;
            aluop    = 3'b000;
            halted   = 1'b0;
            bus_err  = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;

    assign retire = ((state == S_EXEC) && (cls == C_BEQ)) ||
                    ((state == S_MEM) && (cls == C_SW) && mem_ready) ||
                    (state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state != S_HALT && !(state == S_FETCH && !run))
                cyc_q <= cyc_q + 1'b1;
            if (retire)
                ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, wait states, timeout, illegal halt, async reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_sel, ir_write, pc_write, regwrite, alusrc, halted, bus_err;
    logic [1:0]  pcsrc, memtoreg;
    logic [2:0]  aluop;
    logic [31:0] cycle_cnt, instret_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pcsrc(pcsrc), .regwrite(regwrite),
        .memtoreg(memtoreg), .alusrc(alusrc), .aluop(aluop), .halted(halted), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ctl(input logic req, input logic we, input logic sel,
                                        input logic irw, input logic pcw, input logic [1:0] psrc,
                                        input logic rw, input logic [1:0] m2r, input logic as,
                                        input logic [2:0] op, input logic h, input logic be);
        return {req, we, sel, irw, pcw, psrc, rw, m2r, as, op, h, be};
    endfunction

    function automatic logic [15:0] obs();
        return {mem_req, mem_we, mem_sel, ir_write, pc_write, pcsrc, regwrite,
                memtoreg, alusrc, aluop, halted, bus_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        opcode = opc;
        func3  = f3;
        func7  = f7;
    endtask

    // One zero-wait ALU-type instruction; checks fetch, exec controls and plain writeback.
    task automatic alu_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [6:0] f7, input logic as, input logic [2:0] op);
        tick(); set_ir(opc, f3, f7); #1;
        chk({tag, "_fetch"}, obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick();
        tick(); #1;
        chk({tag, "_exec"}, obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,as,op,0,0));
        tick(); #1;
        chk({tag, "_wb"}, obs(), ctl(0,0,0,0,0,2'b00,1,2'b00,0,3'b000,0,0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        set_ir(7'b0000000, 3'b000, 7'b0000000);
        #3;
        chk("reset_ctl", obs(), 16'h0000);
        chk("reset_cyc", cycle_cnt, 32'd0);
        chk("reset_ret", instret_cnt, 32'd0);

        // add x3,x1,x2 with always-ready memory
        tick(); rst_n = 1'b1; set_ir(7'b0110011, 3'b000, 7'b0000000); #1;
        chk("add_fetch", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); #1;
        chk("add_decode", obs(), 16'h0000);
        tick(); #1;
        chk("add_exec", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,0,0));
        tick(); #1;
        chk("add_wb", obs(), ctl(0,0,0,0,0,2'b00,1,2'b00,0,3'b000,0,0));
        tick(); run = 1'b0; #1;
        chk("idle", obs(), 16'h0000);
        chk("add_instret", instret_cnt, PERF ? 32'd1 : 32'd0);
        chk("add_cycles", cycle_cnt, PERF ? 32'd4 : 32'd0);
        tick(); #1;
        chk("idle_ready_ignored", obs(), 16'h0000);
        chk("idle_cycles_frozen", cycle_cnt, PERF ? 32'd4 : 32'd0);

        // LW with three wait states in MEM
        tick(); run = 1'b1; mem_ready = 1'b1; set_ir(7'b0000011, 3'b010, 7'b0000000); #1;
        chk("lw_fetch", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); mem_ready = 1'b0; #1;
        chk("lw_decode", obs(), 16'h0000);
        tick(); #1;
        chk("lw_exec", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,1,3'b011,0,0));
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("lw_mem_wait", obs(), ctl(1,0,1,0,0,2'b00,0,2'b00,1,3'b011,0,0));
        end
        tick(); mem_ready = 1'b1; #1;
        chk("lw_mem_done", obs(), ctl(1,0,1,0,0,2'b00,0,2'b00,1,3'b011,0,0));
        tick(); #1;
        chk("lw_wb", obs(), ctl(0,0,0,0,0,2'b00,1,2'b01,0,3'b000,0,0));

        // BEQ taken then not taken
        tick(); set_ir(7'b1100011, 3'b000, 7'b0000000); #1;
        chk("beq1_fetch", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick();
        tick(); zero = 1'b1; #1;
        chk("beq_taken_exec", obs(), ctl(0,0,0,0,1,2'b01,0,2'b00,0,3'b111,0,0));
        tick(); zero = 1'b0; #1;
        chk("beq2_fetch", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick();
        tick(); #1;
        chk("beq_not_taken_exec", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b111,0,0));

        // SW: fetch waits while run drops, then reset asserted mid-MEM
        tick(); set_ir(7'b0100011, 3'b010, 7'b0000000); mem_ready = 1'b0; #1;
        chk("sw_fetch_wait", obs(), ctl(1,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); run = 1'b0; #1;
        chk("sw_fetch_run_dropped", obs(), ctl(1,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); mem_ready = 1'b1; #1;
        chk("sw_fetch_done", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); mem_ready = 1'b0;
        tick(); #1;
        chk("sw_exec", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,1,3'b011,0,0));
        tick(); #1;
        chk("sw_mem", obs(), ctl(1,1,1,0,0,2'b00,0,2'b00,1,3'b011,0,0));
        #2; rst_n = 1'b0; #1;
        chk("sw_async_reset", obs(), 16'h0000);
        chk("sw_reset_cyc", cycle_cnt, 32'd0);
        chk("sw_reset_ret", instret_cnt, 32'd0);
        tick(); rst_n = 1'b1; #1;
        chk("post_reset_idle", obs(), 16'h0000);

        // JALR and JAL writeback selects
        tick(); run = 1'b1; mem_ready = 1'b1; set_ir(7'b1100111, 3'b000, 7'b0000000); #1;
        chk("jalr_fetch", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick();
        tick(); #1;
        chk("jalr_exec", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,1,3'b011,0,0));
        tick(); #1;
        chk("jalr_wb", obs(), ctl(0,0,0,0,1,2'b10,1,2'b10,0,3'b000,0,0));
        tick(); set_ir(7'b1101111, 3'b000, 7'b0000000);
        tick();
        tick(); #1;
        chk("jal_exec", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,0,0));
        tick(); #1;
        chk("jal_wb", obs(), ctl(0,0,0,0,1,2'b01,1,2'b10,0,3'b000,0,0));

        alu_instr("sub",  7'b0110011, 3'b000, 7'b0100000, 1'b0, 3'b111);
        alu_instr("andi", 7'b0010011, 3'b111, 7'b0000000, 1'b1, 3'b001);
        alu_instr("or",   7'b0110011, 3'b110, 7'b0000000, 1'b0, 3'b000);
        alu_instr("xori", 7'b0010011, 3'b100, 7'b0000000, 1'b1, 3'b010);
        alu_instr("sltu", 7'b0110011, 3'b011, 7'b0000000, 1'b0, 3'b110);

        // Fetch timeout: 16 waiting cycles, then halt with bus error
        tick(); set_ir(7'b0110011, 3'b000, 7'b0000000); mem_ready = 1'b0; #1;
        chk("to_cycle1", obs(), ctl(1,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0));
        for (int i = 0; i < 14; i++) tick();
        tick(); #1;
        chk("to_cycle16", obs(), ctl(1,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); #1;
        chk("to_halt", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,1));
        tick(); mem_ready = 1'b1; #1;
        chk("to_halt_sticky", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,1));

        // Illegal opcode halts without bus error
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; set_ir(7'b1111111, 3'b000, 7'b0000000); #1;
        chk("ill_fetch", obs(), ctl(1,0,0,1,1,2'b00,0,2'b00,0,3'b000,0,0));
        tick(); #1;
        chk("ill_decode", obs(), 16'h0000);
        tick(); #1;
        chk("ill_halt", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,0));
        tick(); #1;
        chk("ill_halt_no_req", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,0));

        // Shift encoding is illegal
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; set_ir(7'b0110011, 3'b001, 7'b0000000);
        tick();
        tick(); #1;
        chk("sll_illegal_halt", obs(), ctl(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
